andgate_bf: RTL and testbench
=============================

ANDGATE_BF -- requirements
Module: andgate_bf

Parameters
REQ-001 WIDTH, default 1, operand and result lane count (legal 1..32).
REQ-002 CNT_W, default 8, width of the high-cycle counter (legal 2..16).

Interface
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 y  output  WIDTH  combinational bitwise AND of a and b.
REQ-006 a  input  WIDTH  operand A.
REQ-007 b  input  WIDTH  operand B.
REQ-008 y_q  output  WIDTH  registered copy of y.
REQ-009 y_rise  output  1  one-cycle pulse when lane 0 of y_q goes 0->1.
REQ-010 hi_cnt  output  CNT_W  count of cycles with lane 0 of y high, saturating.
REQ-011 seen  output  4  sticky flags, one per (a[0],b[0]) combination, index {a[0],b[0]}.
REQ-012 all_seen  output  1  high when all four seen bits are set.
REQ-013 Positional port order SHALL be y, a, b, clk, rst, y_q, y_rise, hi_cnt, seen, all_seen, so a three-port positional hookup (y,a,b) binds correctly.

Function
REQ-014 y SHALL equal a & b per bit at all times, zero latency, independent of clk and rst.
REQ-015 y_q SHALL take the value a & b sampled at each rising clk edge (latency 1 cycle).
REQ-016 y_rise SHALL be registered: high for exactly one cycle following the edge where y_q[0] changes 0->1; low otherwise.
REQ-017 hi_cnt SHALL increment by 1 at each edge where (a[0] & b[0]) = 1.
REQ-018 hi_cnt SHALL saturate at 2^CNT_W-1 and hold; no wrap to 0.
REQ-019 seen[{a[0],b[0]}] SHALL be set at each edge; set bits never clear except by rst.
REQ-020 all_seen SHALL be combinational: AND-reduction of seen.
REQ-021 X/Z on a or b SHALL NOT be masked; y follows Verilog & semantics (0 & X = 0).
REQ-022 Lanes 1..WIDTH-1 SHALL affect only y and y_q; counter, pulse and coverage logic use lane 0 only.

Reset
REQ-023 When rst is high at a rising edge: y_q = 0, y_rise = 0, hi_cnt = 0, seen = 4'b0000 on the following cycle.
REQ-024 rst SHALL have priority over all other updates in the same cycle; no counting or flag setting occurs in a reset cycle.
REQ-025 y SHALL remain purely combinational during reset (rst does not gate y).
REQ-026 Reset mid-operation SHALL clear state identically to power-up reset; after rst deasserts, operation resumes next edge.
REQ-027 No asynchronous reset path; output values before the first reset edge are undefined.

Verification
REQ-028 WIDTH=1, hold {a,b}=00 10ns, 01 20ns, 10 40ns, 11 60ns -> y = 0,0,0,1 within each interval with no clock dependence.
REQ-029 Same sequence with 10ns clk after rst -> y_q follows y one edge late; y_rise pulses once, one cycle after first 11 sample; seen = 4'b1111, all_seen = 1 after first edge in 11 interval.
REQ-030 Hold {a,b}=11 for 300 cycles, CNT_W=8 -> hi_cnt reaches 255 and stays 255.
REQ-031 Assert rst for one cycle during the 11 phase with hi_cnt = 5 -> next cycle hi_cnt = 0, seen = 0, y_q = 0, y still 1; counting resumes after.
REQ-032 WIDTH=4, a=4'b1100, b=4'b1010 -> y = 4'b1000 immediately, y_q = 4'b1000 after one edge; hi_cnt unchanged (lane 0 = 0).
REQ-033 Toggle a[0] 0/1 each cycle with b[0]=1 -> y_rise pulses every second cycle; hi_cnt increments every second cycle.

Source files
------------

// File: rtl/andgate_bf.sv
// -----------------------------------------------------------------------------
// andgate_bf
//
// Purpose:
//   Bitwise AND of two WIDTH-lane operands, plus a small amount of
//   lane-0 observation logic:
//     - y        : combinational a & b (never gated by clock or reset)
//     - y_q      : a & b captured on every rising clk edge
//     - y_rise   : registered one-cycle pulse, high in the same cycle in
//                  which y_q[0] shows a 0->1 change
//     - hi_cnt   : saturating count of edges where a[0] & b[0] = 1
//     - seen     : sticky flags, bit {a[0],b[0]} set at each edge
//     - all_seen : combinational AND-reduction of seen
//
// Ports (positional order is y, a, b first so a plain three-port AND
// hookup binds correctly):
//   y        out [WIDTH-1:0]  combinational a & b
//   a        in  [WIDTH-1:0]  operand A
//   b        in  [WIDTH-1:0]  operand B
//   clk      in               rising-edge clock
//   rst      in               synchronous, active-high reset
//   y_q      out [WIDTH-1:0]  registered a & b
//   y_rise   out              lane-0 rising-edge pulse of y_q
//   hi_cnt   out [CNT_W-1:0]  saturating lane-0 high-cycle count
//   seen     out [3:0]        sticky {a[0],b[0]} combination flags
//   all_seen out              all four combinations observed
//
// Parameters:
//   WIDTH  lane count, 1..32
//   CNT_W  counter width, 2..16
//
// There is no asynchronous reset path: register contents are undefined
// until the first rising edge with rst high.
// -----------------------------------------------------------------------------
module andgate_bf #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    output logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] y_q,
    output logic             y_rise,
    output logic [CNT_W-1:0] hi_cnt,
    output logic [3:0]       seen,
    output logic             all_seen
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // Saturating increment: holds at all-ones instead of wrapping to zero.
    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] cnt,
        input logic             en
    );
        logic [CNT_W-1:0] res;
        if (en && (cnt != CNT_MAX)) begin
            res = cnt + CNT_ONE;
        end else begin
            res = cnt;
        end
        return res;
    endfunction

    // Sets the sticky flag addressed by {a0,b0}; existing bits are kept.
    function automatic logic [3:0] seen_set(
        input logic [3:0] cur,
        input logic       a0,
        input logic       b0
    );
        logic [3:0] res;
        case ({a0, b0})
            2'b00:   res = cur | 4'b0001;
            2'b01:   res = cur | 4'b0010;
            2'b10:   res = cur | 4'b0100;
            2'b11:   res = cur | 4'b1000;
            default: res = cur;
        endcase
        return res;
    endfunction

    logic [WIDTH-1:0] and_s;
    logic             lane0_s;

    logic [WIDTH-1:0] yq_q,   yq_d;
    logic             rise_q, rise_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic [3:0]       seen_q, seen_d;

    // Combinational AND; continuous assignment keeps Verilog X semantics.
    assign and_s   = a & b;
    assign lane0_s = and_s[0];

    // Next-state logic for all lane-0 observation registers.
    always_comb begin
        yq_d   = and_s;
        // Pulse is registered together with y_q so that it is visible in
        // exactly the cycle where y_q[0] shows its new value of 1.
        rise_d = lane0_s & ~yq_q[0];
        cnt_d  = sat_inc(cnt_q, lane0_s);
        seen_d = seen_set(seen_q, a[0], b[0]);
    end

    // State registers; reset takes priority over every update.
    always_ff @(posedge clk) begin
        if (rst) begin
            yq_q   <= {WIDTH{1'b0}};
            rise_q <= 1'b0;
            cnt_q  <= CNT_ZERO;
            seen_q <= 4'b0000;
        end else begin
            yq_q   <= yq_d;
            rise_q <= rise_d;
            cnt_q  <= cnt_d;
            seen_q <= seen_d;
        end
    end

    assign y        = and_s;
    assign y_q      = yq_q;
    assign y_rise   = rise_q;
    assign hi_cnt   = cnt_q;
    assign seen     = seen_q;
    assign all_seen = &seen_q;

endmodule

// File: tb/tb_andgate_bf.sv
// -----------------------------------------------------------------------------
// tb_andgate_bf
//
// Self-checking bench for andgate_bf (WIDTH=4, CNT_W=8). A table of
// directed vectors with hand-computed expectations is applied first,
// followed by hand-written sequences for saturation, mid-run reset and
// lane-0 toggling.
// -----------------------------------------------------------------------------
module tb_andgate_bf;

    logic       clk;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] y;
    logic [3:0] y_q;
    logic       y_rise;
    logic [7:0] hi_cnt;
    logic [3:0] seen;
    logic       all_seen;

    int checks;
    int failures;

    andgate_bf #(.WIDTH(4), .CNT_W(8)) u_dut (
        .y        (y),
        .a        (a),
        .b        (b),
        .clk      (clk),
        .rst      (rst),
        .y_q      (y_q),
        .y_rise   (y_rise),
        .hi_cnt   (hi_cnt),
        .seen     (seen),
        .all_seen (all_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net: the stimulus never waits on DUT events, but stop anyway.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       rst;
        logic [3:0] exp_y;
        logic [3:0] exp_yq;
        logic       exp_rise;
        logic [7:0] exp_cnt;
        logic [3:0] exp_seen;
        logic       exp_all;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive inputs mid-cycle, then let one rising edge pass.
    task automatic step(input logic [3:0] ta, input logic [3:0] tb_v, input logic trst);
        @(negedge clk);
        a   = ta;
        b   = tb_v;
        rst = trst;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step(4'b0000, 4'b0000, 1'b1);
        step(4'b0000, 4'b0000, 1'b1);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        a   = 4'b0000;
        b   = 4'b0000;
        rst = 1'b1;

        //              a        b        rst   y        yq       rise  cnt    seen     all
        vecs[0]  = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'd0, 4'b0000, 1'b0};
        vecs[1]  = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'd0, 4'b0001, 1'b0};
        vecs[2]  = '{4'b0000, 4'b0001, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'd0, 4'b0011, 1'b0};
        vecs[3]  = '{4'b0001, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'd0, 4'b0111, 1'b0};
        vecs[4]  = '{4'b1100, 4'b1010, 1'b0, 4'b1000, 4'b1000, 1'b0, 8'd0, 4'b0111, 1'b0};
        vecs[5]  = '{4'b0001, 4'b0001, 1'b0, 4'b0001, 4'b0001, 1'b1, 8'd1, 4'b1111, 1'b1};
        vecs[6]  = '{4'b1111, 4'b0111, 1'b0, 4'b0111, 4'b0111, 1'b0, 8'd2, 4'b1111, 1'b1};
        vecs[7]  = '{4'b0110, 4'b0011, 1'b0, 4'b0010, 4'b0010, 1'b0, 8'd2, 4'b1111, 1'b1};
        vecs[8]  = '{4'b0001, 4'b0001, 1'b0, 4'b0001, 4'b0001, 1'b1, 8'd3, 4'b1111, 1'b1};
        vecs[9]  = '{4'b0001, 4'b0001, 1'b1, 4'b0001, 4'b0000, 1'b0, 8'd0, 4'b0000, 1'b0};
        vecs[10] = '{4'b0001, 4'b0001, 1'b0, 4'b0001, 4'b0001, 1'b1, 8'd1, 4'b1000, 1'b0};
        vecs[11] = '{4'b0000, 4'b1111, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'd1, 4'b1010, 1'b0};

        do_reset();

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            a   = vecs[i].a;
            b   = vecs[i].b;
            rst = vecs[i].rst;
            #1;
            check($sformatf("v%0d_y_comb", i), {28'd0, y}, {28'd0, vecs[i].exp_y});
            @(posedge clk);
            #1;
            check($sformatf("v%0d_y_q", i),      {28'd0, y_q},     {28'd0, vecs[i].exp_yq});
            check($sformatf("v%0d_y_rise", i),   {31'd0, y_rise},  {31'd0, vecs[i].exp_rise});
            check($sformatf("v%0d_hi_cnt", i),   {24'd0, hi_cnt},  {24'd0, vecs[i].exp_cnt});
            check($sformatf("v%0d_seen", i),     {28'd0, seen},    {28'd0, vecs[i].exp_seen});
            check($sformatf("v%0d_all_seen", i), {31'd0, all_seen}, {31'd0, vecs[i].exp_all});
            check($sformatf("v%0d_y_post", i),   {28'd0, y},       {28'd0, vecs[i].exp_y});
        end

        // ---------------- combinational timing, no clock dependence ----------------
        begin
            logic [3:0] pat_a [4];
            logic [3:0] pat_b [4];
            logic [3:0] pat_y [4];
            pat_a = '{4'b0000, 4'b0000, 4'b0001, 4'b0001};
            pat_b = '{4'b0000, 4'b0001, 4'b0000, 4'b0001};
            pat_y = '{4'b0000, 4'b0000, 4'b0000, 4'b0001};
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                a = pat_a[k];
                b = pat_b[k];
                #2;
                check($sformatf("comb_y_%0d", k), {28'd0, y}, {28'd0, pat_y[k]});
            end
        end

        // ---------------- mid-run reset with hi_cnt = 5 ----------------
        do_reset();
        for (int k = 1; k <= 5; k++) step(4'b0001, 4'b0001, 1'b0);
        check("mr_cnt_before", {24'd0, hi_cnt}, 32'd5);
        step(4'b0001, 4'b0001, 1'b1);
        check("mr_cnt_cleared",  {24'd0, hi_cnt}, 32'd0);
        check("mr_seen_cleared", {28'd0, seen},   32'd0);
        check("mr_yq_cleared",   {28'd0, y_q},    32'd0);
        check("mr_rise_cleared", {31'd0, y_rise}, 32'd0);
        check("mr_y_during_rst", {28'd0, y},      32'd1);
        step(4'b0001, 4'b0001, 1'b0);
        check("mr_cnt_resume",  {24'd0, hi_cnt}, 32'd1);
        check("mr_rise_resume", {31'd0, y_rise}, 32'd1);
        check("mr_seen_resume", {28'd0, seen},   32'h8);
        check("mr_yq_resume",   {28'd0, y_q},    32'd1);

        // ---------------- lane-0 toggle: pulse and count every second cycle ----------------
        do_reset();
        begin
            int exp_cnt;
            logic a0;
            exp_cnt = 0;
            for (int k = 0; k < 8; k++) begin
                a0 = ((k % 2) == 0) ? 1'b1 : 1'b0;
                step({3'b000, a0}, 4'b0001, 1'b0);
                if (a0) exp_cnt++;
                check($sformatf("tg%0d_rise", k), {31'd0, y_rise}, {31'd0, a0});
                check($sformatf("tg%0d_cnt", k),  {24'd0, hi_cnt}, exp_cnt);
            end
        end

        // ---------------- saturation: 300 cycles of 11 ----------------
        do_reset();
        begin
            int exp_cnt;
            exp_cnt = 0;
            for (int k = 1; k <= 300; k++) begin
                step(4'b0001, 4'b0001, 1'b0);
                exp_cnt = (k > 255) ? 255 : k;
                check($sformatf("sat%0d_cnt", k), {24'd0, hi_cnt}, exp_cnt);
            end
            check("sat_rise_low", {31'd0, y_rise}, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
